sign_extension: RTL and testbench

SIGN_EXTENSION -- requirements
Module: sign_extension

---
 rtl/sign_extension.sv | 87 ++++++++
 tb/tb_sign_extension.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sign_extension.sv
// Immediate-field sign/zero extension: combinational sext of the full field plus a
// registered, mode-selected, stallable result. Define SIGNEXT_ZEROEXT_EN to make mode 11 zero-extend.
module sign_extension #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET_N,
  input  logic [IN_WIDTH-1:0]  In,
  input  logic [1:0]           I_Mode,
  input  logic                 I_Valid,
  input  logic                 I_Stall,
  output logic [OUT_WIDTH-1:0] Out,
  output logic [OUT_WIDTH-1:0] O_Ext,
  output logic                 O_Valid
);

  typedef enum logic [1:0] {
    MODE_SEXT16 = 2'b00,
    MODE_SEXT8  = 2'b01,
    MODE_SEXT5  = 2'b10,
    MODE_ZEXT16 = 2'b11
  } mode_e;

  logic [OUT_WIDTH-1:0] sext_full;
  logic [OUT_WIDTH-1:0] sext_8;
  logic [OUT_WIDTH-1:0] sext_5;
  logic [OUT_WIDTH-1:0] zext_full;
  logic [OUT_WIDTH-1:0] ext_sel;

  logic [OUT_WIDTH-1:0] ext_q, ext_d;
  logic                 valid_q, valid_d;

  // Size casts of signed operands replicate the operand MSB into the upper bits.
  assign sext_full = OUT_WIDTH'($signed(In));
  assign sext_8    = OUT_WIDTH'($signed(In[7:0]));
  assign sext_5    = OUT_WIDTH'($signed(In[4:0]));
  assign zext_full = OUT_WIDTH'(In);

  assign Out = sext_full;

  always_comb begin
    ext_sel = sext_full;
    unique case (mode_e'(I_Mode))
      MODE_SEXT16: ext_sel = sext_full;
      MODE_SEXT8:  ext_sel = sext_8;
      MODE_SEXT5:  ext_sel = sext_5;
`ifdef SIGNEXT_ZEROEXT_EN
      MODE_ZEXT16: ext_sel = zext_full;
`else
      MODE_ZEXT16: ext_sel = sext_full;
`endif
      default:     ext_sel = sext_full;
    endcase
  end

`ifndef SIGNEXT_ZEROEXT_EN
  logic unused_zext;
  assign unused_zext = ^zext_full;
`endif

  // Idle cycles drop O_Valid but keep the last result; stalls freeze both.
  always_comb begin
    ext_d   = ext_q;
    valid_d = valid_q;
    if (!I_Stall) begin
      valid_d = I_Valid;
      if (I_Valid) begin
        ext_d = ext_sel;
      end
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      ext_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      valid_q <= valid_d;
    end
  end

  assign O_Ext   = ext_q;
  assign O_Valid = valid_q;

endmodule

// File: tb/tb_sign_extension.sv
// Self-checking bench for sign_extension: directed scenarios followed by random traffic
// against an arithmetic reference model.
module tb_sign_extension;

  logic        I_CLOCK;
  logic        I_RESET_N;
  logic [15:0] In;
  logic [1:0]  I_Mode;
  logic        I_Valid;
  logic        I_Stall;
  logic [31:0] Out;
  logic [31:0] O_Ext;
  logic        O_Valid;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_ext;
  logic        m_valid;

  sign_extension #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
    .I_CLOCK  (I_CLOCK),
    .I_RESET_N(I_RESET_N),
    .In       (In),
    .I_Mode   (I_Mode),
    .I_Valid  (I_Valid),
    .I_Stall  (I_Stall),
    .Out      (Out),
    .O_Ext    (O_Ext),
    .O_Valid  (O_Valid)
  );

  initial I_CLOCK = 1'b0;
  always #5 I_CLOCK = ~I_CLOCK;

  // Two's-complement interpretation of a k-bit field, reduced modulo 2^32.
  function automatic logic [31:0] as_signed(input longint unsigned v, input int k);
    longint x;
    longint span;
    span = longint'(1) << k;
    x = longint'(v % span);
    if (x >= span / 2) x = x - span;
    return 32'(x);
  endfunction

  function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] m);
    case (m)
      2'd0: return as_signed(longint'(v), 16);
      2'd1: return as_signed(longint'(v), 8);
      2'd2: return as_signed(longint'(v), 5);
`ifdef SIGNEXT_ZEROEXT_EN
      default: return 32'(longint'(v));
`else
      default: return as_signed(longint'(v), 16);
`endif
    endcase
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, update the model from inputs held at that edge, then compare.
  task automatic step(input string tag);
    @(posedge I_CLOCK);
    if (I_RESET_N && !I_Stall) begin
      if (I_Valid) m_ext = ref_ext(In, I_Mode);
      m_valid = I_Valid;
    end
    #1;
    check32({tag, "_ext"}, O_Ext, m_ext);
    check1({tag, "_vld"}, O_Valid, m_valid);
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d, input logic [1:0] m);
    I_Valid = v;
    I_Stall = s;
    In      = d;
    I_Mode  = m;
  endtask

  initial begin
    m_ext   = '0;
    m_valid = 1'b0;
    I_RESET_N = 1'b0;
    drive(1'b1, 1'b0, 16'h1234, 2'd0);
    #2;
    check32("reset_ext", O_Ext, 32'h0);
    check1("reset_vld", O_Valid, 1'b0);
    @(posedge I_CLOCK);
    #1;
    check32("reset_hold_ext", O_Ext, 32'h0);
    I_RESET_N = 1'b1;

    // Combinational path, independent of mode
    drive(1'b0, 1'b0, 16'h8000, 2'd1);
    #1 check32("comb_8000", Out, 32'hFFFF8000);
    In = 16'h7FFF; I_Mode = 2'd2;
    #1 check32("comb_7fff", Out, 32'h00007FFF);

    drive(1'b1, 1'b0, 16'h12F0, 2'd1);
    step("sext8");
    check32("sext8_const", O_Ext, 32'hFFFFFFF0);

    drive(1'b1, 1'b0, 16'h0010, 2'd2);
    step("sext5_neg");
    check32("sext5_neg_const", O_Ext, 32'hFFFFFFF0);
    drive(1'b1, 1'b0, 16'h000F, 2'd2);
    step("sext5_pos");
    check32("sext5_pos_const", O_Ext, 32'h0000000F);

    drive(1'b1, 1'b0, 16'h8001, 2'd3);
    step("mode11");
`ifdef SIGNEXT_ZEROEXT_EN
    check32("mode11_const", O_Ext, 32'h00008001);
`else
    check32("mode11_const", O_Ext, 32'hFFFF8001);
`endif

    // Idle drops valid but holds data
    drive(1'b0, 1'b0, 16'hAAAA, 2'd0);
    step("idle");
    check32("idle_hold", O_Ext, 32'hFFFF8001 & ref_ext(16'h8001, 2'd3));

    // Stall hold and release
    drive(1'b1, 1'b0, 16'h0005, 2'd0);
    step("load5");
    drive(1'b1, 1'b1, 16'hFFFF, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check32("stall_const", O_Ext, 32'h00000005);
    end
    I_Stall = 1'b0;
    step("release");
    check32("release_const", O_Ext, 32'hFFFFFFFF);

    // Async reset pulse during a stall
    I_Stall = 1'b1;
    step("pre_rst_stall");
    I_RESET_N = 1'b0;
    #1;
    m_ext = '0;
    m_valid = 1'b0;
    check32("midrst_ext", O_Ext, 32'h0);
    check1("midrst_vld", O_Valid, 1'b0);
    I_RESET_N = 1'b1;
    drive(1'b0, 1'b0, 16'h1111, 2'd0);
    step("post_rst");
    drive(1'b1, 1'b0, 16'h0080, 2'd1);
    step("post_rst_cap");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            16'($urandom), 2'($urandom_range(0, 3)));
      #1 check32("rand_comb", Out, as_signed(longint'(In), 16));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
